// File: rtl/wt_cache_pkg.sv
// -----------------------------------------------------------------------------
// wt_cache_pkg
// Shared geometry, types and helpers for the write-through dcache miss path.
//   - Cache geometry: physical address width, associativity, line/offset/index
//     and tag widths, memory transaction ID width.
//   - miss_resp_state_e : miss responder FSM states.
//   - mshr_t            : the single outstanding-miss holding register.
//   - lowest_zero_oh()  : one-hot of the lowest cleared valid bit (free way).
// -----------------------------------------------------------------------------
package wt_cache_pkg;

  localparam int unsigned PLEN                = 32;
  localparam int unsigned DCACHE_SET_ASSOC    = 4;
  localparam int unsigned DCACHE_LINE_WIDTH   = 128;
  localparam int unsigned DCACHE_OFFSET_WIDTH = $clog2(DCACHE_LINE_WIDTH / 8);
  localparam int unsigned DCACHE_INDEX_WIDTH  = 12;
  localparam int unsigned DCACHE_CL_IDX_WIDTH = DCACHE_INDEX_WIDTH - DCACHE_OFFSET_WIDTH;
  localparam int unsigned DCACHE_TAG_WIDTH    = PLEN - DCACHE_INDEX_WIDTH;
  localparam int unsigned CACHE_ID_WIDTH      = 2;

  // Owner index storage width; supports up to 16 read controllers.
  localparam int unsigned MISS_PORT_IDX_W     = 4;
  localparam int unsigned REPL_W              = (DCACHE_SET_ASSOC > 1) ? $clog2(DCACHE_SET_ASSOC) : 1;

  typedef enum logic [1:0] {
    IDLE,
    MEM_REQ,
    WAIT_RTRN
  } miss_resp_state_e;

  typedef struct packed {
    logic [PLEN-1:0]             paddr;
    logic                        nc;
    logic [2:0]                  size;
    logic [DCACHE_SET_ASSOC-1:0] way_oh;
    logic [MISS_PORT_IDX_W-1:0]  owner;
    logic                        valid;
  } mshr_t;

  // One-hot of the lowest-index zero bit; all-zero result when every way is valid.
  function automatic logic [DCACHE_SET_ASSOC-1:0] lowest_zero_oh(
    input logic [DCACHE_SET_ASSOC-1:0] vld
  );
    logic found;
    lowest_zero_oh = '0;
    found          = 1'b0;
    for (int unsigned i = 0; i < DCACHE_SET_ASSOC; i++) begin
      if (!vld[i] && !found) begin
        lowest_zero_oh[i] = 1'b1;
        found             = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/wt_dcache_miss_arb.sv
// -----------------------------------------------------------------------------
// wt_dcache_miss_arb
// Combinational round-robin arbiter for the miss requests.
//   req_i     : request vector, one bit per read controller
//   ptr_i     : last winner; the search begins at ptr_i+1 (wrapping)
//   gnt_vld_o : at least one request present
//   gnt_oh_o  : one-hot grant
//   gnt_idx_o : index of the winner (becomes the next pointer)
// -----------------------------------------------------------------------------
module wt_dcache_miss_arb #(
  parameter int unsigned  NumPorts = 2,
  localparam int unsigned IdxW     = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
  input  logic [NumPorts-1:0] req_i,
  input  logic [IdxW-1:0]     ptr_i,
  output logic                gnt_vld_o,
  output logic [NumPorts-1:0] gnt_oh_o,
  output logic [IdxW-1:0]     gnt_idx_o
);

  always_comb begin
    int unsigned cand;
    logic [IdxW-1:0] cand_idx;
    gnt_vld_o = 1'b0;
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      // ptr_i < NumPorts, so a single wrap subtraction suffices.
      cand = 32'(ptr_i) + 1 + i;
      if (cand >= NumPorts) begin
        cand = cand - NumPorts;
      end
      cand_idx = IdxW'(cand);
      if (!gnt_vld_o && req_i[cand_idx]) begin
        gnt_vld_o          = 1'b1;
        gnt_oh_o[cand_idx] = 1'b1;
        gnt_idx_o          = cand_idx;
      end
    end
  end

endmodule

// File: rtl/wt_dcache_miss_resp.sv
// -----------------------------------------------------------------------------
// wt_dcache_miss_resp
// Responder end of the dcache read-controller miss interface. Holds a single
// outstanding miss (MSHR), issues the memory request, then writes the returned
// line into the chosen way (or bypasses it for non-cacheable misses) and flags
// completion to the owning controller.
//   clk_i, rst_i            : clock, synchronous active-high reset
//   miss_req/ack/replay/rtrn: per-port miss handshake from the read controllers
//   miss_paddr/nc/size/vld  : per-port miss attributes
//   mem_*_o / mem_gnt_i     : outgoing memory request (ID = MemTxId)
//   mem_rtrn_*_i            : memory return
//   wr_cl_*_o               : cacheline write / NC bypass toward the dcache mem
// -----------------------------------------------------------------------------
module wt_dcache_miss_resp
  import wt_cache_pkg::*;
#(
  parameter int unsigned               NumPorts = 2,
  parameter logic [CACHE_ID_WIDTH-1:0] MemTxId  = CACHE_ID_WIDTH'(1)
) (
  input  logic                                       clk_i,
  input  logic                                       rst_i,
  input  logic [NumPorts-1:0]                        miss_req_i,
  output logic [NumPorts-1:0]                        miss_ack_o,
  output logic [NumPorts-1:0]                        miss_replay_o,
  output logic [NumPorts-1:0]                        miss_rtrn_vld_o,
  input  logic [NumPorts-1:0][PLEN-1:0]              miss_paddr_i,
  input  logic [NumPorts-1:0]                        miss_nc_i,
  input  logic [NumPorts-1:0][2:0]                   miss_size_i,
  input  logic [NumPorts-1:0][DCACHE_SET_ASSOC-1:0]  miss_vld_bits_i,
  output logic                                       mem_req_o,
  input  logic                                       mem_gnt_i,
  output logic [PLEN-1:0]                            mem_paddr_o,
  output logic [2:0]                                 mem_size_o,
  output logic                                       mem_nc_o,
  output logic [CACHE_ID_WIDTH-1:0]                  mem_id_o,
  input  logic                                       mem_rtrn_vld_i,
  input  logic [CACHE_ID_WIDTH-1:0]                  mem_rtrn_id_i,
  input  logic [DCACHE_LINE_WIDTH-1:0]               mem_rtrn_data_i,
  output logic                                       wr_cl_vld_o,
  output logic                                       wr_cl_nc_o,
  output logic [DCACHE_SET_ASSOC-1:0]                wr_cl_we_o,
  output logic [DCACHE_TAG_WIDTH-1:0]                wr_cl_tag_o,
  output logic [DCACHE_CL_IDX_WIDTH-1:0]             wr_cl_idx_o,
  output logic [DCACHE_OFFSET_WIDTH-1:0]             wr_cl_off_o,
  output logic [DCACHE_LINE_WIDTH-1:0]               wr_cl_data_o
);

  localparam int unsigned IdxW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

  miss_resp_state_e       state_q, state_d;
  mshr_t                  mshr_q, mshr_d;
  logic [IdxW-1:0]        ptr_q, ptr_d;
  logic [REPL_W-1:0]      repl_q, repl_d;

  logic                   arb_vld;
  logic [NumPorts-1:0]    arb_oh;
  logic [IdxW-1:0]        arb_idx;

  logic [DCACHE_SET_ASSOC-1:0] cap_vld;
  logic [DCACHE_SET_ASSOC-1:0] cap_way;
  logic                        rtrn_hit;

  wt_dcache_miss_arb #(
    .NumPorts(NumPorts)
  ) i_miss_arb (
    .req_i    (miss_req_i),
    .ptr_i    (ptr_q),
    .gnt_vld_o(arb_vld),
    .gnt_oh_o (arb_oh),
    .gnt_idx_o(arb_idx)
  );

  // A return only completes while a miss is held; after a reset the MSHR is
  // invalid, so stale returns fall through.
  assign rtrn_hit = mem_rtrn_vld_i && (mem_rtrn_id_i == MemTxId) && mshr_q.valid;

  always_comb begin
    state_d         = state_q;
    mshr_d          = mshr_q;
    ptr_d           = ptr_q;
    repl_d          = repl_q;
    cap_vld         = '0;
    cap_way         = '0;

    miss_ack_o      = '0;
    miss_replay_o   = '0;
    miss_rtrn_vld_o = '0;
    mem_req_o       = 1'b0;
    mem_paddr_o     = '0;
    mem_size_o      = '0;
    mem_nc_o        = 1'b0;
    mem_id_o        = '0;
    wr_cl_vld_o     = 1'b0;
    wr_cl_nc_o      = 1'b0;
    wr_cl_we_o      = '0;
    wr_cl_tag_o     = '0;
    wr_cl_idx_o     = '0;
    wr_cl_off_o     = '0;
    wr_cl_data_o    = '0;

    if (!rst_i) begin
      unique case (state_q)
        IDLE: begin
          if (arb_vld) begin
            miss_ack_o = arb_oh;
            ptr_d      = arb_idx;
            cap_vld    = miss_vld_bits_i[arb_idx];
            // Free way if any; otherwise the replacement counter picks the
            // victim and advances. NC misses never touch the array.
            if (miss_nc_i[arb_idx]) begin
              cap_way = '0;
            end else if (&cap_vld) begin
              cap_way = {{(DCACHE_SET_ASSOC-1){1'b0}}, 1'b1} << repl_q;
              if (repl_q == REPL_W'(DCACHE_SET_ASSOC - 1)) begin
                repl_d = '0;
              end else begin
                repl_d = repl_q + 1'b1;
              end
            end else begin
              cap_way = lowest_zero_oh(cap_vld);
            end
            mshr_d.paddr  = miss_paddr_i[arb_idx];
            mshr_d.nc     = miss_nc_i[arb_idx];
            mshr_d.size   = miss_size_i[arb_idx];
            mshr_d.way_oh = cap_way;
            mshr_d.owner  = MISS_PORT_IDX_W'(arb_idx);
            mshr_d.valid  = 1'b1;
            state_d       = MEM_REQ;
          end
        end

        MEM_REQ: begin
          mem_req_o = 1'b1;
          mem_nc_o  = mshr_q.nc;
          mem_id_o  = MemTxId;
          if (mshr_q.nc) begin
            mem_paddr_o = mshr_q.paddr;
            mem_size_o  = mshr_q.size;
          end else begin
            mem_paddr_o = {mshr_q.paddr[PLEN-1:DCACHE_OFFSET_WIDTH], {DCACHE_OFFSET_WIDTH{1'b0}}};
            mem_size_o  = 3'b111;
          end
          if (mem_gnt_i) begin
            state_d = WAIT_RTRN;
          end
        end

        WAIT_RTRN: begin
          if (rtrn_hit) begin
            wr_cl_vld_o  = 1'b1;
            wr_cl_nc_o   = mshr_q.nc;
            wr_cl_we_o   = mshr_q.nc ? '0 : mshr_q.way_oh;
            wr_cl_tag_o  = mshr_q.paddr[PLEN-1 -: DCACHE_TAG_WIDTH];
            wr_cl_idx_o  = mshr_q.paddr[DCACHE_INDEX_WIDTH-1:DCACHE_OFFSET_WIDTH];
            wr_cl_off_o  = mshr_q.paddr[DCACHE_OFFSET_WIDTH-1:0];
            wr_cl_data_o = mem_rtrn_data_i;
            for (int unsigned p = 0; p < NumPorts; p++) begin
              miss_rtrn_vld_o[p] = (mshr_q.owner == MISS_PORT_IDX_W'(p));
            end
            mshr_d.valid = 1'b0;
            state_d      = IDLE;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase

      // While busy, a request to the line already being fetched is told to
      // re-read the cache; anything else simply waits for IDLE.
      if (state_q != IDLE) begin
        for (int unsigned p = 0; p < NumPorts; p++) begin
          miss_replay_o[p] = miss_req_i[p] && mshr_q.valid && !mshr_q.nc &&
                             (miss_paddr_i[p][PLEN-1:DCACHE_OFFSET_WIDTH] ==
                              mshr_q.paddr[PLEN-1:DCACHE_OFFSET_WIDTH]);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      mshr_q  <= '0;
      ptr_q   <= '0;
      repl_q  <= '0;
    end else begin
      state_q <= state_d;
      mshr_q  <= mshr_d;
      ptr_q   <= ptr_d;
      repl_q  <= repl_d;
    end
  end

endmodule
